// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control decoder for the EX stage. Decodes ALUOp and
// inst[31:21] into a 4-bit ALU code and holds off upstream while MUL/DIV run.
module alu_ctrl_seq #(
   parameter int          MUL_LAT    = 4,
   parameter int          DIV_LAT    = 16,
   parameter int unsigned ENABLE_EXT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [10:0] inst31_21,
   input  logic [1:0]  ALUOp,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  control_line,
   output logic        set_flags,
   output logic        unit_start,
   output logic        busy,
   output logic        illegal
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [10:0] OPC_EOR  = 11'b11001010000;
   localparam logic [10:0] OPC_LSL  = 11'b11010011011;
   localparam logic [10:0] OPC_LSR  = 11'b11010011010;
   localparam logic [10:0] OPC_ADDS = 11'b10101011000;
   localparam logic [10:0] OPC_SUBS = 11'b11101011000;
   localparam logic [10:0] OPC_MUL  = 11'b10011011000;
   localparam logic [10:0] OPC_DIV  = 11'b10011010110;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_outValid;
   logic [3:0]       r_ctrl;
   logic             r_flags;
   logic             r_illegal;
   logic             r_unitStart;
   logic             r_busy;

   logic [3:0]       w_code;
   logic             w_flags;
   logic             w_illegal;
   logic             w_isMul;
   logic             w_isDiv;
   logic             w_multi;
   logic [CNT_W-1:0] w_load;
   logic             w_accept;

   // Decode; anything unrecognised (including all extended ops in legacy mode) falls back to add.
   always_comb begin
      w_code    = 4'b0010;
      w_flags   = 1'b0;
      w_illegal = 1'b0;
      w_isMul   = 1'b0;
      w_isDiv   = 1'b0;
      case (ALUOp)
         2'b00: w_code = 4'b0010;
         2'b01: w_code = 4'b0111;
         2'b11: w_illegal = 1'b1;
         2'b10: begin
            case (inst31_21)
               OPC_SUB: w_code = 4'b0110;
               OPC_AND: w_code = 4'b0000;
               OPC_ORR: w_code = 4'b0001;
               default: begin
                  if (ENABLE_EXT != 0) begin
                     case (inst31_21)
                        OPC_EOR:  w_code = 4'b0011;
                        OPC_LSL:  w_code = 4'b1000;
                        OPC_LSR:  w_code = 4'b1001;
                        OPC_ADDS: begin
                           w_code  = 4'b0010;
                           w_flags = 1'b1;
                        end
                        OPC_SUBS: begin
                           w_code  = 4'b0110;
                           w_flags = 1'b1;
                        end
                        OPC_MUL: begin
                           w_code  = 4'b1010;
                           w_isMul = 1'b1;
                        end
                        OPC_DIV: begin
                           w_code  = 4'b1011;
                           w_isDiv = 1'b1;
                        end
                        default: w_code = 4'b0010;
                     endcase
                  end
               end
            endcase
         end
         default: w_code = 4'b0010;
      endcase
   end

   assign w_multi  = w_isMul || w_isDiv;
   assign w_load   = w_isMul ? MUL_LOAD : DIV_LOAD;
   assign in_ready = (r_state == ST_IDLE) && (!r_outValid || out_ready);
   assign w_accept = in_valid && in_ready;

   // Sequencer: the counter only decrements while nonzero, so it never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_outValid  <= 1'b0;
         r_ctrl      <= 4'b0000;
         r_flags     <= 1'b0;
         r_illegal   <= 1'b0;
         r_unitStart <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_unitStart <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_ctrl    <= w_code;
                  r_flags   <= w_flags;
                  r_illegal <= w_illegal;
                  if (w_multi) begin
                     r_outValid  <= 1'b0;
                     r_cnt       <= w_load;
                     r_unitStart <= 1'b1;
                     r_busy      <= 1'b1;
                     r_state     <= ST_WAIT;
                  end else begin
                     r_outValid <= 1'b1;
                  end
               end else if (out_ready) begin
                  r_outValid <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  r_outValid <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
         endcase
      end
   end

   assign out_valid    = r_outValid;
   assign control_line = r_ctrl;
   assign set_flags    = r_flags;
   assign illegal      = r_illegal;
   assign unit_start   = r_unitStart;
   assign busy         = r_busy;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: three instances (full, legacy, LAT=1/2) checked
// against a table-driven reference model of the decode and its latencies.
module tb_alu_ctrl_seq;

   localparam int N = 3;

   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_EOR  = 11'b11001010000;
   localparam logic [10:0] OP_LSL  = 11'b11010011011;
   localparam logic [10:0] OP_LSR  = 11'b11010011010;
   localparam logic [10:0] OP_ADDS = 11'b10101011000;
   localparam logic [10:0] OP_SUBS = 11'b11101011000;
   localparam logic [10:0] OP_MUL  = 11'b10011011000;
   localparam logic [10:0] OP_DIV  = 11'b10011010110;
   localparam logic [10:0] OP_UNK  = 11'b11111111111;

   function automatic int mulLatOf(input int d);
      return (d == 2) ? 1 : 4;
   endfunction

   function automatic int divLatOf(input int d);
      return (d == 2) ? 2 : 16;
   endfunction

   function automatic int extOf(input int d);
      return (d == 1) ? 0 : 1;
   endfunction

   typedef struct {
      logic [10:0] opc;
      logic [3:0]  cl;
      logic        sf;
      int          kind;
      bit          ext;
   } row_t;

   typedef struct {
      int         dut;
      logic [3:0] cl;
      logic       sf;
      logic       ill;
      int         readyCycle;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic        inValid  [N];
   logic        outReady [N];
   logic [10:0] inst     [N];
   logic [1:0]  aluOp    [N];
   wire         inReady  [N];
   wire         outValid [N];
   wire  [3:0]  ctrlLine [N];
   wire         setFlags [N];
   wire         unitStart[N];
   wire         busy     [N];
   wire         illegal  [N];

   int   compared = 0;
   int   failed   = 0;
   int   cycle    = 0;
   bit   randReady = 1'b0;

   row_t opTable [10];
   exp_t expQ [$];
   exp_t cur [N];
   bit   pending [N];
   int   startAt [N];
   int   busyFrom[N];
   int   busyTo  [N];

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   for (genvar g = 0; g < N; g++) begin : gDut
      alu_ctrl_seq #(
         .MUL_LAT   (mulLatOf(g)),
         .DIV_LAT   (divLatOf(g)),
         .ENABLE_EXT(extOf(g))
      ) uDut (
         .clk         (clk),
         .rst_n       (rst_n),
         .in_valid    (inValid[g]),
         .in_ready    (inReady[g]),
         .inst31_21   (inst[g]),
         .ALUOp       (aluOp[g]),
         .out_valid   (outValid[g]),
         .out_ready   (outReady[g]),
         .control_line(ctrlLine[g]),
         .set_flags   (setFlags[g]),
         .unit_start  (unitStart[g]),
         .busy        (busy[g]),
         .illegal     (illegal[g])
      );
   end

   task automatic checkOutput(input string name, input int d, input logic [31:0] act,
                              input logic [31:0] expv);
      compared++;
      if (act !== expv) begin
         failed++;
         $display("[TB] FAIL %s dut%0d t=%0t got=%0h expected=%0h", name, d, $time, act, expv);
      end
   endtask

   // Reference model: table lookup of the opcode, extended rows only where enabled.
   function automatic exp_t decodeModel(input int d, input logic [1:0] op, input logic [10:0] ins);
      exp_t e;
      e.dut = d;
      e.cl  = 4'b0010;
      e.sf  = 1'b0;
      e.ill = (op == 2'b11);
      e.readyCycle = 0;
      if (op == 2'b01) e.cl = 4'b0111;
      else if (op == 2'b10) begin
         foreach (opTable[i])
            if (opTable[i].opc == ins && (!opTable[i].ext || extOf(d) != 0)) begin
               e.cl = opTable[i].cl;
               e.sf = opTable[i].sf;
            end
      end
      return e;
   endfunction

   function automatic int latModel(input int d, input logic [1:0] op, input logic [10:0] ins);
      int lat = 0;
      if (op == 2'b10 && extOf(d) != 0) begin
         foreach (opTable[i])
            if (opTable[i].opc == ins && opTable[i].kind == 1) lat = mulLatOf(d);
            else if (opTable[i].opc == ins && opTable[i].kind == 2) lat = divLatOf(d);
      end
      return lat;
   endfunction

   function automatic bit pendingAny();
      bit p = 1'b0;
      for (int d = 0; d < N; d++) if (pending[d]) p = 1'b1;
      return p;
   endfunction

   // Drive one request and wait (bounded) for acceptance; the expectation is queued on accept.
   task automatic applyStimulus(input int d, input logic [1:0] op, input logic [10:0] ins);
      bit   acc = 1'b0;
      int   tries = 0;
      int   k = 0;
      int   lat;
      exp_t e;
      inValid[d] = 1'b1;
      aluOp[d]   = op;
      inst[d]    = ins;
      while (!acc && tries < 400) begin
         @(negedge clk);
         acc = inReady[d];
         k   = cycle;
         @(posedge clk);
         #1;
         tries++;
      end
      inValid[d] = 1'b0;
      aluOp[d]   = 2'($urandom);
      inst[d]    = 11'($urandom);
      if (!acc) begin
         checkOutput("accept_timeout", d, 32'(inReady[d]), 32'd1);
      end else begin
         lat = latModel(d, op, ins);
         e = decodeModel(d, op, ins);
         e.readyCycle = k + 1 + lat;
         expQ.push_back(e);
         if (lat > 0) begin
            startAt[d]  = k + 1;
            busyFrom[d] = k + 1;
            busyTo[d]   = k + lat;
         end
      end
   endtask

   task automatic checkResetState(input int d);
      checkOutput("rst_out_valid", d, 32'(outValid[d]), 32'd0);
      checkOutput("rst_control_line", d, 32'(ctrlLine[d]), 32'd0);
      checkOutput("rst_set_flags", d, 32'(setFlags[d]), 32'd0);
      checkOutput("rst_unit_start", d, 32'(unitStart[d]), 32'd0);
      checkOutput("rst_busy", d, 32'(busy[d]), 32'd0);
      checkOutput("rst_illegal", d, 32'(illegal[d]), 32'd0);
      checkOutput("rst_in_ready", d, 32'(inReady[d]), 32'd1);
   endtask

   task automatic waitDrain();
      int t = 0;
      randReady = 1'b0;
      for (int d = 0; d < N; d++) outReady[d] = 1'b1;
      while ((expQ.size() != 0 || pendingAny()) && t < 300) begin
         @(posedge clk);
         t++;
      end
      repeat (2) @(posedge clk);
      #1;
      checkOutput("drain_queue", -1, 32'(expQ.size()), 32'd0);
   endtask

   task automatic randomTraffic(input int d, input int count);
      logic [1:0]  op;
      logic [10:0] ins;
      int          r;
      for (int i = 0; i < count; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) op = 2'b00;
         else if (r == 1) op = 2'b01;
         else if (r == 2) op = 2'b11;
         else op = 2'b10;
         if ($urandom_range(0, 4) == 0) ins = 11'($urandom);
         else ins = opTable[$urandom_range(0, 9)].opc;
         applyStimulus(d, op, ins);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
      end
   endtask

   always begin
      @(posedge clk);
      #1;
      if (randReady)
         for (int d = 0; d < N; d++) outReady[d] = ($urandom_range(0, 3) != 0);
   end

   // Monitor: pops an expectation whenever a new result appears, then checks it until drained.
   always @(negedge clk) begin
      int idx;
      if (rst_n) begin
         for (int d = 0; d < N; d++) begin
            checkOutput("unit_start", d, 32'(unitStart[d]), 32'(cycle == startAt[d]));
            checkOutput("busy", d, 32'(busy[d]), 32'(cycle >= busyFrom[d] && cycle <= busyTo[d]));
            if (outValid[d]) begin
               if (!pending[d]) begin
                  idx = -1;
                  for (int i = expQ.size() - 1; i >= 0; i--) if (expQ[i].dut == d) idx = i;
                  if (idx < 0) begin
                     checkOutput("unexpected_out_valid", d, 32'(outValid[d]), 32'd0);
                  end else begin
                     cur[d] = expQ[idx];
                     expQ.delete(idx);
                     pending[d] = 1'b1;
                     checkOutput("latency_cycle", d, 32'(cycle), 32'(cur[d].readyCycle));
                  end
               end
               if (pending[d]) begin
                  checkOutput("control_line", d, 32'(ctrlLine[d]), 32'(cur[d].cl));
                  checkOutput("set_flags", d, 32'(setFlags[d]), 32'(cur[d].sf));
                  checkOutput("illegal", d, 32'(illegal[d]), 32'(cur[d].ill));
                  if (outReady[d]) pending[d] = 1'b0;
               end
            end else if (pending[d]) begin
               checkOutput("out_valid_withdrawn", d, 32'(outValid[d]), 32'd1);
               pending[d] = 1'b0;
            end
         end
      end
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog t=%0t got=running expected=finished", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      opTable[0] = '{OP_SUB,  4'b0110, 1'b0, 0, 1'b0};
      opTable[1] = '{OP_AND,  4'b0000, 1'b0, 0, 1'b0};
      opTable[2] = '{OP_ORR,  4'b0001, 1'b0, 0, 1'b0};
      opTable[3] = '{OP_EOR,  4'b0011, 1'b0, 0, 1'b1};
      opTable[4] = '{OP_LSL,  4'b1000, 1'b0, 0, 1'b1};
      opTable[5] = '{OP_LSR,  4'b1001, 1'b0, 0, 1'b1};
      opTable[6] = '{OP_ADDS, 4'b0010, 1'b1, 0, 1'b1};
      opTable[7] = '{OP_SUBS, 4'b0110, 1'b1, 0, 1'b1};
      opTable[8] = '{OP_MUL,  4'b1010, 1'b0, 1, 1'b1};
      opTable[9] = '{OP_DIV,  4'b1011, 1'b0, 2, 1'b1};
      for (int d = 0; d < N; d++) begin
         inValid[d]  = 1'b0;
         outReady[d] = 1'b0;
         inst[d]     = '0;
         aluOp[d]    = '0;
         pending[d]  = 1'b0;
         startAt[d]  = -1;
         busyFrom[d] = -1;
         busyTo[d]   = -2;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < N; d++) checkResetState(d);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int d = 0; d < N; d++) outReady[d] = 1'b1;

      $display("[TB] back-to-back basic decode");
      applyStimulus(0, 2'b00, 11'($urandom));
      applyStimulus(0, 2'b01, 11'($urandom));
      applyStimulus(0, 2'b10, OP_SUB);
      applyStimulus(0, 2'b10, OP_AND);
      applyStimulus(0, 2'b10, OP_ORR);

      $display("[TB] multi-cycle MUL/DIV");
      applyStimulus(0, 2'b10, OP_MUL);
      @(negedge clk);
      checkOutput("wait_in_ready", 0, 32'(inReady[0]), 32'd0);
      applyStimulus(0, 2'b10, OP_DIV);
      applyStimulus(2, 2'b10, OP_MUL);
      applyStimulus(2, 2'b10, OP_DIV);
      applyStimulus(2, 2'b10, OP_AND);

      $display("[TB] extended ops, full and legacy");
      for (int d = 0; d < 2; d++) begin
         applyStimulus(d, 2'b10, OP_ADDS);
         applyStimulus(d, 2'b10, OP_SUBS);
         applyStimulus(d, 2'b10, OP_EOR);
         applyStimulus(d, 2'b10, OP_LSL);
         applyStimulus(d, 2'b10, OP_LSR);
      end
      applyStimulus(1, 2'b10, OP_MUL);
      applyStimulus(1, 2'b10, OP_DIV);

      $display("[TB] illegal and unknown opcode");
      applyStimulus(0, 2'b11, OP_SUB);
      applyStimulus(0, 2'b10, OP_UNK);
      waitDrain();

      $display("[TB] back-pressure with pending MUL");
      outReady[0] = 1'b0;
      applyStimulus(0, 2'b00, 11'($urandom));
      fork
         applyStimulus(0, 2'b10, OP_MUL);
         begin
            repeat (3) begin
               @(negedge clk);
               checkOutput("bp_in_ready", 0, 32'(inReady[0]), 32'd0);
               checkOutput("bp_out_valid", 0, 32'(outValid[0]), 32'd1);
            end
            @(posedge clk);
            #1;
            outReady[0] = 1'b1;
         end
      join
      waitDrain();

      $display("[TB] randomized traffic");
      randReady = 1'b1;
      fork
         randomTraffic(0, 40);
         randomTraffic(1, 40);
         randomTraffic(2, 40);
      join
      waitDrain();

      $display("[TB] reset during DIV");
      applyStimulus(0, 2'b10, OP_DIV);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < N; d++) checkResetState(d);
      for (int i = expQ.size() - 1; i >= 0; i--) if (expQ[i].dut == 0) expQ.delete(i);
      pending[0]  = 1'b0;
      startAt[0]  = -1;
      busyFrom[0] = -1;
      busyTo[0]   = -2;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      applyStimulus(0, 2'b10, OP_ORR);
      waitDrain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, handshaked successor to the combinational ALU control decoder. Decodes `ALUOp` plus the `inst31_21` opcode field into an ALU control code, adds the LEGv8 extended operations (EOR, LSL, LSR, ADDS/SUBS flag setting, MUL, DIV), and sequences multi-cycle MUL/DIV by holding off upstream for a parameterised latency. Sits between the main control unit / ID stage and the EX-stage ALU.

## Interface
Parameters:
- `MUL_LAT`, default 4: cycles from MUL acceptance to result valid, ≥1.
- `DIV_LAT`, default 16: cycles from DIV acceptance to result valid, ≥1.
- `ENABLE_EXT`, default 1: 1 decodes the extended ops; 0 gives legacy behaviour, where every extended opcode decodes as add (`0010`) and is single-cycle.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: the decode request is valid.
- `in_ready` out 1: the block can accept a request this cycle.
- `inst31_21` in 11: instruction bits [31:21].
- `ALUOp` in 2: ALU operation class from main control.
- `out_valid` out 1: `control_line` and `set_flags` are valid.
- `out_ready` in 1: the consumer takes the output this cycle.
- `control_line` out 4: ALU control code.
- `set_flags` out 1: the instruction updates NZCV.
- `unit_start` out 1: one-cycle start pulse to the MUL/DIV unit.
- `busy` out 1: a multi-cycle op is in progress.
- `illegal` out 1: qualified by `out_valid`; set when `ALUOp` is `11`.

## Operation
Decode, evaluated at acceptance:
- `ALUOp` `00` gives `0010` (LDUR/STUR).
- `ALUOp` `01` gives `0111` (CBZ pass-B).
- `ALUOp` `11` gives `0010`, `illegal=1`, single-cycle.
- `ALUOp` `10`, by `inst31_21`:
  - SUB `11001011000` gives `0110`.
  - AND `10001010000` gives `0000`.
  - ORR `10101010000` gives `0001`.
- Extended, `ALUOp` `10`, only when `ENABLE_EXT=1`:
  - EOR `11001010000` gives `0011`.
  - LSL `11010011011` gives `1000`.
  - LSR `11010011010` gives `1001`.
  - ADDS `10101011000` gives `0010` with `set_flags=1`.
  - SUBS `11101011000` gives `0110` with `set_flags=1`.
  - MUL `10011011000` gives `1010`, multi-cycle with `MUL_LAT`.
  - SDIV/UDIV `10011010110` gives `1011`, multi-cycle with `DIV_LAT`.
- Any other opcode gives `0010`.
- `set_flags` is 0 except for ADDS/SUBS. `illegal` is 0 except for `ALUOp` `11`.

States:
- IDLE:
  - `in_ready = !out_valid || out_ready`.
  - Acceptance is `in_valid && in_ready`.
  - Single-cycle accept: output registers load the decode and `out_valid=1` next cycle.
  - Multi-cycle accept: output registers load the decode, `out_valid=0`, counter loads LAT−1, `unit_start=1` next cycle, go to WAIT.
  - `out_valid` clears on `out_ready` unless a new accept reloads it in the same cycle.
- WAIT:
  - `in_ready=0`, `busy=1`, `out_valid=0`.
  - The counter decrements each cycle.
  - When counter==0: `out_valid=1`, go to IDLE.
- `control_line`, `set_flags` and `illegal` are stable while `out_valid=1 && !out_ready`.
- The counter width is sized to hold max(`MUL_LAT`,`DIV_LAT`)−1 and does not wrap.

Reset values:
- State is IDLE.
- `out_valid`, `control_line`, `set_flags`, `unit_start`, `busy` and `illegal` are all 0.
- `in_ready=1`.

## Timing
- Single-cycle latency: accept at edge N gives `out_valid` after edge N. Throughput is 1 per cycle when `out_ready=1`.
- Multi-cycle latency:
  - Accept at edge N.
  - `unit_start` and `busy` are high in the cycle after edge N.
  - `out_valid` rises LAT cycles after acceptance; `busy` falls in the same cycle.
  - `unit_start` is high for exactly 1 cycle per MUL/DIV.
- LAT=1: the block spends one cycle in WAIT with counter 0, so `busy` and `unit_start` are high for one cycle and `out_valid` follows on the next edge.
- Back-pressure: with `out_valid=1` and `out_ready=0`, `in_ready=0` and no accept is possible, including a multi-cycle issue.
- Simultaneous output drain and input accept in IDLE: the new result replaces the old; no bubble.
- `inst31_21` and `ALUOp` are don't-care when `in_valid=0` or `in_ready=0`.
- Reset asserted mid-WAIT: immediately IDLE, all outputs at reset values, no late `out_valid` or `unit_start`.

## Test plan
- Reset, then back-to-back requests with `out_ready=1`: ALUOp 00, 01, then 10 with SUB, AND, ORR. Outputs `0010`, `0111`, `0110`, `0000`, `0001` appear on consecutive cycles, one cycle after each accept.
- MUL with `MUL_LAT=4`: `unit_start` pulses once, `in_ready=0` and `busy=1` for 4 cycles, then `out_valid=1`, `control_line=1010`, `busy=0`. The same sequence with DIV and `DIV_LAT=16` gives `1011` after 16 cycles.
- ADDS, SUBS, EOR, LSL, LSR with `ENABLE_EXT=1` give `0010` with flags set, `0110` with flags set, `0011`, `1000`, `1001`. With `ENABLE_EXT=0` all five give `0010`, flags clear, and MUL gives `0010` single-cycle with no `unit_start`.
- Hold `out_ready=0` for 3 cycles after a result: `out_valid` and `control_line` are stable, `in_ready=0`, and a pending MUL is not started until the drain.
- `ALUOp=11`: `control_line=0010`, `illegal=1`, single-cycle. An unknown opcode `11111111111` with `ALUOp=10` gives `0010`, `illegal=0`.
- Drop `rst_n` for one cycle at cycle 2 of a 16-cycle DIV: outputs return to reset values at once, with no `out_valid` afterwards. A following ORR completes normally.
